// File: rtl/rns_mul_sequencer_pkg.sv
// Shared constants and state encoding for the RNS residue multiply sequencer.
package rns_mul_sequencer_pkg;

  localparam int unsigned RES_W  = 3;
  localparam int unsigned NCH    = 3;
  localparam int unsigned PROD_W = 2 * RES_W;

  localparam int unsigned M0_DEF = 7;
  localparam int unsigned M1_DEF = 5;
  localparam int unsigned M2_DEF = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CH0  = 3'd1,
    CH1  = 3'd2,
    CH2  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/rns_mul_sequencer_modmul_core.sv
// Combinational residue multiplier: 3x3 full product reduced modulo m.
module rns_modmul_core
  import rns_mul_sequencer_pkg::*;
(
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  input  logic [RES_W-1:0] m,
  output logic [RES_W-1:0] p
);

  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] rem;

  always_comb begin
    prod = {{RES_W{1'b0}}, a} * {{RES_W{1'b0}}, b};
    // m is always one of the nonzero channel moduli
    rem  = prod % {{RES_W{1'b0}}, m};
    p    = rem[RES_W-1:0];
  end

endmodule

// File: rtl/rns_mul_sequencer.sv
// Three-channel RNS multiplier sharing one mod-multiply core, one channel per cycle.
// Optional residue range flag enabled with `define RESIDUE_CHECK_EN.
module rns_mul_sequencer
  import rns_mul_sequencer_pkg::*;
#(
  parameter int unsigned M0 = M0_DEF,
  parameter int unsigned M1 = M1_DEF,
  parameter int unsigned M2 = M2_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NCH*RES_W-1:0]   a_res,
  input  logic [NCH*RES_W-1:0]   b_res,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCH*RES_W-1:0]   prod_res,
  output logic                   err
);

  localparam logic [RES_W-1:0] MOD0 = RES_W'(M0);
  localparam logic [RES_W-1:0] MOD1 = RES_W'(M1);
  localparam logic [RES_W-1:0] MOD2 = RES_W'(M2);

  state_t                 state;
  logic [NCH*RES_W-1:0]   a_q;
  logic [NCH*RES_W-1:0]   b_q;
  logic [RES_W-1:0]       core_a;
  logic [RES_W-1:0]       core_b;
  logic [RES_W-1:0]       core_m;
  logic [RES_W-1:0]       core_p;

  // Operand slice and modulus follow the channel being processed this cycle.
  always_comb begin
    core_a = '0;
    core_b = '0;
    core_m = MOD0;
    case (state)
      CH0: begin core_a = a_q[2:0]; core_b = b_q[2:0]; core_m = MOD0; end
      CH1: begin core_a = a_q[5:3]; core_b = b_q[5:3]; core_m = MOD1; end
      CH2: begin core_a = a_q[8:6]; core_b = b_q[8:6]; core_m = MOD2; end
      default: ;
    endcase
  end

  rns_modmul_core u_core (
    .a (core_a),
    .b (core_b),
    .m (core_m),
    .p (core_p)
  );

`ifdef RESIDUE_CHECK_EN
  logic err_q;
  logic range_bad;

  always_comb begin
    range_bad = (a_res[2:0] >= MOD0) || (b_res[2:0] >= MOD0) ||
                (a_res[5:3] >= MOD1) || (b_res[5:3] >= MOD1) ||
                (a_res[8:6] >= MOD2) || (b_res[8:6] >= MOD2);
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      prod_res  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef RESIDUE_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a_res;
            b_q      <= b_res;
            in_ready <= 1'b0;
            state    <= CH0;
`ifdef RESIDUE_CHECK_EN
            err_q    <= range_bad;
`endif
          end
        end
        CH0: begin
          prod_res[2:0] <= core_p;
          state         <= CH1;
        end
        CH1: begin
          prod_res[5:3] <= core_p;
          state         <= CH2;
        end
        CH2: begin
          prod_res[8:6] <= core_p;
          out_valid     <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rns_mul_sequencer.sv
// Directed self-checking bench for rns_mul_sequencer with default moduli (7,5,3).
module tb_rns_mul_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] a_res;
  logic [8:0] b_res;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] prod_res;
  logic       err;

  always #5 clk = ~clk;

  rns_mul_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_res     (a_res),
    .b_res     (b_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod_res  (prod_res),
    .err       (err)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      name;
    logic [8:0] a;
    logic [8:0] b;
    logic [8:0] p;
    logic       oor;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [8:0] pk(input int unsigned x2, input int unsigned x1,
                                    input int unsigned x0);
    return {3'(x2), 3'(x1), 3'(x0)};
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_err(input logic oor);
`ifdef RESIDUE_CHECK_EN
    return oor;
`else
    return 1'b0 & oor;
`endif
  endfunction

  task automatic run_op(input vec_t v, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({v.name, "_ready"}, 9'(in_ready), 9'd1);
    a_res     = v.a;
    b_res     = v.b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_res    = '1;
    b_res    = '1;
    @(negedge clk);
    chk({v.name, "_ch0_ov"}, 9'(out_valid), 9'd0);
    chk({v.name, "_ch0_rdy"}, 9'(in_ready), 9'd0);
    @(negedge clk);
    @(negedge clk);
    chk({v.name, "_ch2_ov"}, 9'(out_valid), 9'd0);
    @(negedge clk);
    chk({v.name, "_done_ov"}, 9'(out_valid), 9'd1);
    chk({v.name, "_prod"}, prod_res, v.p);
    chk({v.name, "_err"}, 9'(err), 9'(exp_err(v.oor)));
    if (hold > 0) begin
      in_valid = 1'b1;
      a_res    = pk(1, 1, 1);
      b_res    = pk(2, 2, 2);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({v.name, "_hold_prod"}, prod_res, v.p);
        chk({v.name, "_hold_rdy"}, 9'(in_ready), 9'd0);
        chk({v.name, "_hold_ov"}, 9'(out_valid), 9'd1);
        chk({v.name, "_hold_err"}, 9'(err), 9'(exp_err(v.oor)));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({v.name, "_idle_rdy"}, 9'(in_ready), 9'd1);
    chk({v.name, "_idle_ov"}, 9'(out_valid), 9'd0);
  endtask

  logic [8:0] expq[$];
  int         acc[$];
  int         idx;
  int         got;
  int         seen;

  initial begin
    vecs[0] = '{"nominal", pk(2, 4, 3), pk(2, 3, 5), pk(1, 2, 1), 1'b0};
    vecs[1] = '{"max_in",  pk(2, 4, 6), pk(2, 4, 6), pk(1, 1, 1), 1'b0};
    vecs[2] = '{"zero_a",  pk(0, 0, 0), pk(2, 4, 6), pk(0, 0, 0), 1'b0};
    vecs[3] = '{"ident",   pk(1, 1, 1), pk(2, 3, 4), pk(2, 3, 4), 1'b0};
    vecs[4] = '{"oor_a0",  pk(0, 1, 7), pk(0, 1, 3), pk(0, 1, 0), 1'b1};
    vecs[5] = '{"oor_all", pk(5, 6, 7), pk(7, 7, 7), pk(2, 2, 0), 1'b1};
    vecs[6] = '{"mixed",   pk(1, 2, 3), pk(2, 2, 2), pk(2, 4, 6), 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_res     = pk(3, 3, 3);
    b_res     = pk(3, 3, 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 9'(in_ready), 9'd1);
    chk("rst_ov", 9'(out_valid), 9'd0);
    chk("rst_prod", prod_res, 9'd0);
    chk("rst_err", 9'(err), 9'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_noaccept_rdy", 9'(in_ready), 9'd1);

    for (int i = 0; i < 7; i++) run_op(vecs[i], 0);

    // Backpressure: ten cycles held in DONE with a competing request.
    run_op(vecs[0], 10);
    @(negedge clk);
    chk("bp_after_rdy", 9'(in_ready), 9'd1);

    // Reset while processing channel 1.
    a_res    = vecs[1].a;
    b_res    = vecs[1].b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_rdy", 9'(in_ready), 9'd1);
    chk("midrst_ov", 9'(out_valid), 9'd0);
    chk("midrst_prod", prod_res, 9'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_result", 9'(seen), 9'd0);

    // Back-to-back with in_valid held; garbage offered while busy.
    idx = 0;
    got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        got++;
        if (expq.size() > 0) chk("b2b_prod", prod_res, expq.pop_front());
        else chk("b2b_extra", prod_res, 9'h1FF ^ prod_res);
      end
      if (in_ready && idx < 4) begin
        a_res    = vecs[idx].a;
        b_res    = vecs[idx].b;
        in_valid = 1'b1;
        expq.push_back(vecs[idx].p);
        acc.push_back(cyc);
        idx++;
      end else if (idx < 4) begin
        a_res    = 9'($urandom);
        b_res    = 9'($urandom);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("b2b_count", 9'(got), 9'd4);
    chk("b2b_accepts", 9'(acc.size()), 9'd4);
    for (int i = 1; i < acc.size(); i++)
      chk("b2b_interval", 9'(acc[i] - acc[i-1]), 9'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/rns_mul_sequencer.md
RNS_MUL_SEQUENCER -- requirements
Module: rns_mul_sequencer

Interface
REQ-001 The module SHALL have parameter M0, default 7, the modulus for channel 0.
REQ-002 The module SHALL have parameter M1, default 5, the modulus for channel 1.
REQ-003 The module SHALL have parameter M2, default 3, the modulus for channel 2; all moduli SHALL be in 2..7 and pairwise coprime.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-006 The module SHALL have port in_valid, input, 1 bit, indicating that the operand pair is valid.
REQ-007 The module SHALL have port in_ready, output, 1 bit, indicating that the block accepts operands.
REQ-008 The module SHALL have port a_res, input, 9 bits, holding operand A residues {a2,a1,a0}, 3 bits each, with a0 in [2:0].
REQ-009 The module SHALL have port b_res, input, 9 bits, holding operand B residues in the same packing as a_res.
REQ-010 The module SHALL have port out_valid, output, 1 bit, indicating that the result is valid.
REQ-011 The module SHALL have port out_ready, input, 1 bit, indicating that the consumer accepts the result.
REQ-012 The module SHALL have port prod_res, output, 9 bits, holding result residues {p2,p1,p0}, where pk = (ak*bk) mod Mk.
REQ-013 The module SHALL have port err, output, 1 bit, the residue-range error flag (see Configuration).

Function
REQ-014 The block SHALL time-multiplex one modular-multiply core across the three channels, one channel per clock cycle.
REQ-015 The FSM SHALL have states IDLE, CH0, CH1, CH2 and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-017 In IDLE, in_valid=1 SHALL latch a_res and b_res into internal registers and move the FSM to CH0; if in_valid=0 the FSM SHALL remain in IDLE.
REQ-018 In each CHk state, the core SHALL compute (ak*bk) on a 6-bit full product, reduce it mod Mk to 3 bits, write the result into slot pk of the result register, and advance the FSM (CH0->CH1->CH2->DONE).
REQ-019 Latency SHALL be fixed: out_valid rises on the third rising edge after the accepting edge.
REQ-020 In DONE, the FSM SHALL move to IDLE if out_ready=1, and otherwise SHALL hold with prod_res and err stable.
REQ-021 Minimum initiation interval SHALL be 5 cycles; in_valid while the block is busy SHALL be ignored, with no operand capture.
REQ-022 Input changes after acceptance SHALL have no effect on the operation in progress.
REQ-023 A residue of 0 on either operand SHALL yield pk=0.
REQ-024 Out-of-range residues (ak>=Mk or bk>=Mk) SHALL still be reduced correctly, with the product taken mod Mk.

Reset
REQ-025 While rst=1 at a clock edge, the FSM SHALL go to IDLE and prod_res, err, out_valid and the operand registers SHALL clear to 0, with in_ready=1 after reset.
REQ-026 Reset asserted mid-operation (CHx or DONE) SHALL abort the operation and discard any result; no out_valid SHALL follow.

Configuration
REQ-027 With RESIDUE_CHECK_EN defined, on acceptance err SHALL be registered as 1 if any ak>=Mk or bk>=Mk; err SHALL be held through DONE and cleared on the next acceptance.
REQ-028 With RESIDUE_CHECK_EN undefined, err SHALL be tied to 0 and no comparison logic SHALL be built.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding constants, the RES_W=3 and NCH=3 constants, and the default moduli.
REQ-030 The block SHALL contain one sub-module, rns_modmul_core, a combinational 3x3 multiply followed by a 6-bit mod-M reduction, instantiated once with modulus selected per state.

Verification
REQ-031 Nominal case: a=(a2,a1,a0)=(2,4,3), b=(2,3,5) with defaults -> prod_res=(1,2,1), out_valid on the 3rd edge after acceptance, err=0.
REQ-032 Maximum in-range operands: a=b=(2,4,6) -> prod_res=(1,1,1).
REQ-033 Backpressure: hold out_ready=0 for 10 cycles in DONE -> prod_res stable, in_ready=0, and a new in_valid is ignored; out_ready=1 -> IDLE on the next edge.
REQ-034 Reset during CH1 -> next cycle state IDLE, out_valid=0, prod_res=0, and no result emitted.
REQ-035 With RESIDUE_CHECK_EN defined: a0=7, b0=3 -> err=1 and p0=0; without the macro -> err=0 and the same p0.
REQ-036 Back-to-back operands with in_valid held at 1 and out_ready=1 -> exactly one acceptance per 5 cycles, and results in order.
